// File: rtl/rps_input_sampler.sv
// Rock-paper-scissors button front end: synchronizes and debounces six raw buttons on
// slow-clock ticks, emits press pulses, and locks one choice per player into a round.
module rps_input_sampler #(
  parameter int unsigned DB_TICKS = 4
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       slow_clk_i,
  input  logic [5:0] btn_i,
  input  logic       round_ready_i,
  output logic [5:0] btn_level_o,
  output logic [5:0] btn_press_o,
  output logic [1:0] p1_choice_o,
  output logic [1:0] p2_choice_o,
  output logic       round_valid_o
);

  localparam int unsigned CntW = (DB_TICKS > 2) ? $clog2(DB_TICKS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_TICKS - 1);

  logic [5:0]           sync1_q, sync2_q;
  logic                 slow_q;
  logic                 tick;
  logic [5:0][CntW-1:0] cnt_q, cnt_d;
  logic [5:0]           level_q, level_d, level_dly_q;
  logic [5:0]           press;
  logic [1:0]           p1_q, p1_d, p2_q, p2_d;
  logic                 valid_q, valid_d;

  // slow_clk_i already lives in the clk_i domain, so only its edge is detected
  assign tick = slow_clk_i & ~slow_q;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      slow_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      slow_q  <= slow_clk_i;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick) begin
      for (int i = 0; i < 6; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign press = level_q & ~level_dly_q;

  function automatic logic [1:0] encode_choice(input logic [2:0] p);
    if (p[0]) begin
      encode_choice = 2'b01;
    end else if (p[1]) begin
      encode_choice = 2'b10;
    end else if (p[2]) begin
      encode_choice = 2'b11;
    end else begin
      encode_choice = 2'b00;
    end
  endfunction

  // While a round is pending, presses are ignored; acceptance clears everything at once
  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    valid_d = valid_q;
    if (valid_q) begin
      if (round_ready_i) begin
        p1_d    = 2'b00;
        p2_d    = 2'b00;
        valid_d = 1'b0;
      end
    end else begin
      if (p1_q == 2'b00) begin
        p1_d = encode_choice(press[2:0]);
      end
      if (p2_q == 2'b00) begin
        p2_d = encode_choice(press[5:3]);
      end
      valid_d = (p1_q != 2'b00) && (p2_q != 2'b00);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      p1_q    <= 2'b00;
      p2_q    <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      valid_q <= valid_d;
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press;
  assign p1_choice_o   = p1_q;
  assign p2_choice_o   = p2_q;
  assign round_valid_o = valid_q;

endmodule

// File: tb/tb_rps_input_sampler.sv
// Bench for rps_input_sampler: directed button scenarios checked every cycle against a
// behavioural model, plus literal expectations at key points of each scenario.
module tb_rps_input_sampler;

  localparam int unsigned DbTicks = 4;

  logic       clk_i = 1'b0;
  logic       reset_n;
  logic       slow_clk_i = 1'b0;
  logic [5:0] btn_i;
  logic       round_ready_i;
  logic [5:0] btn_level_o;
  logic [5:0] btn_press_o;
  logic [1:0] p1_choice_o;
  logic [1:0] p2_choice_o;
  logic       round_valid_o;

  int n_checks = 0;
  int n_pass   = 0;
  int press_cnt[6];
  int cyc = 0;

  rps_input_sampler #(.DB_TICKS(DbTicks)) dut (
    .clk_i         (clk_i),
    .reset_n       (reset_n),
    .slow_clk_i    (slow_clk_i),
    .btn_i         (btn_i),
    .round_ready_i (round_ready_i),
    .btn_level_o   (btn_level_o),
    .btn_press_o   (btn_press_o),
    .p1_choice_o   (p1_choice_o),
    .p2_choice_o   (p2_choice_o),
    .round_valid_o (round_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Divided clock: period 8 cycles, changed away from the active edge
  always @(negedge clk_i) begin
    cyc = cyc + 1;
    slow_clk_i = ((cyc % 8) >= 4);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0] m_hist0, m_hist1;   // raw samples one and two edges old
  logic [5:0] m_level, m_level_prev;
  bit         m_slow_prev;
  int         m_run[6];           // consecutive ticks on which the sample disagreed
  logic [1:0] m_p1, m_p2;
  bit         m_valid;
  logic [5:0] m_press;
  bit         m_both;

  function automatic logic [1:0] pick(input logic [2:0] p);
    if (p[0]) return 2'b01;
    if (p[1]) return 2'b10;
    if (p[2]) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      m_hist0 = '0; m_hist1 = '0; m_level = '0; m_level_prev = '0;
      m_slow_prev = 0; m_p1 = '0; m_p2 = '0; m_valid = 0;
      for (int i = 0; i < 6; i++) m_run[i] = 0;
    end else begin
      m_press = m_level & ~m_level_prev;
      if (m_valid) begin
        if (round_ready_i) begin
          m_p1 = '0; m_p2 = '0; m_valid = 0;
        end
      end else begin
        m_both = (m_p1 != 0) && (m_p2 != 0);
        if (m_p1 == 0) m_p1 = pick(m_press[2:0]);
        if (m_p2 == 0) m_p2 = pick(m_press[5:3]);
        m_valid = m_both;
      end
      m_level_prev = m_level;
      if (slow_clk_i && !m_slow_prev) begin
        for (int i = 0; i < 6; i++) begin
          if (m_hist1[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DbTicks) begin
              m_level[i] = m_hist1[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_slow_prev = slow_clk_i;
      m_hist1 = m_hist0;
      m_hist0 = btn_i;
    end
  end

  // Per-cycle comparison against the model, plus press pulse counting
  always @(posedge clk_i) begin
    #1;
    check("level", {2'b0, btn_level_o}, {2'b0, m_level});
    check("press", {2'b0, btn_press_o}, {2'b0, m_level & ~m_level_prev});
    check("p1", {6'b0, p1_choice_o}, {6'b0, m_p1});
    check("p2", {6'b0, p2_choice_o}, {6'b0, m_p2});
    check("valid", {7'b0, round_valid_o}, {7'b0, m_valid});
    for (int i = 0; i < 6; i++) if (btn_press_o[i]) press_cnt[i]++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) press_cnt[i] = 0;
  endtask

  initial begin
    bit found;
    int lat;
    reset_n = 1'b0;
    btn_i = '0;
    round_ready_i = 1'b0;
    clear_counts();
    cycles(3);
    check("rst_level", {2'b0, btn_level_o}, 8'h00);
    check("rst_valid", {7'b0, round_valid_o}, 8'h00);
    reset_n = 1'b1;

    // Stable P1 rock press
    clear_counts();
    btn_i = 6'b000001;
    cycles(40);
    check("s1_level", {2'b0, btn_level_o}, 8'h01);
    check("s1_p1", {6'b0, p1_choice_o}, 8'h01);
    check("s1_pulses", 8'(press_cnt[0]), 8'd1);
    btn_i = '0;
    cycles(40);
    check("s1_fall_level", {2'b0, btn_level_o}, 8'h00);
    check("s1_fall_nopulse", 8'(press_cnt[0]), 8'd1);

    // Bounce on P1 paper: 2 high ticks, 1 low tick, then high
    clear_counts();
    btn_i = 6'b000010;
    cycles(16);
    btn_i = '0;
    cycles(8);
    btn_i = 6'b000010;
    cycles(24);
    check("s2_not_yet", {7'b0, btn_level_o[1]}, 8'h00);
    cycles(16);
    check("s2_level", {7'b0, btn_level_o[1]}, 8'h01);
    check("s2_pulses", 8'(press_cnt[1]), 8'd1);
    check("s2_p1_kept", {6'b0, p1_choice_o}, 8'h01);
    btn_i = '0;
    cycles(40);

    // Full round: P1 paper, P2 scissors
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    check("s3_cleared", {6'b0, p1_choice_o}, 8'h00);
    btn_i = 6'b100010;
    cycles(40);
    check("s3_p1", {6'b0, p1_choice_o}, 8'h02);
    check("s3_p2", {6'b0, p2_choice_o}, 8'h03);
    check("s3_valid", {7'b0, round_valid_o}, 8'h01);
    btn_i = '0;
    cycles(40);
    btn_i = 6'b000001;
    cycles(40);
    check("s3_no_overwrite", {6'b0, p1_choice_o}, 8'h02);
    check("s3_held", {7'b0, round_valid_o}, 8'h01);
    btn_i = '0;
    cycles(40);
    round_ready_i = 1'b1;
    cycles(1);
    round_ready_i = 1'b0;
    check("s3_acc_p1", {6'b0, p1_choice_o}, 8'h00);
    check("s3_acc_p2", {6'b0, p2_choice_o}, 8'h00);
    check("s3_acc_valid", {7'b0, round_valid_o}, 8'h00);

    // Simultaneous P1 rock+scissors, then P2 press coinciding with accept
    clear_counts();
    btn_i = 6'b000101;
    cycles(40);
    check("s4_p1_prio", {6'b0, p1_choice_o}, 8'h01);
    check("s4_level", {2'b0, btn_level_o}, 8'h05);
    check("s4_press_both", 8'(press_cnt[0] + press_cnt[2]), 8'd2);
    btn_i = '0;
    cycles(40);
    btn_i = 6'b001000;
    cycles(40);
    check("s4_p2", {6'b0, p2_choice_o}, 8'h01);
    check("s4_valid", {7'b0, round_valid_o}, 8'h01);
    btn_i = '0;
    cycles(40);
    btn_i = 6'b010000;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_i);
      #2;
      if (btn_press_o[4]) begin
        found = 1;
        break;
      end
    end
    check("s4_press_seen", {7'b0, found}, 8'h01);
    round_ready_i = 1'b1;
    @(posedge clk_i);
    #2;
    round_ready_i = 1'b0;
    check("s4_p2_ignored", {6'b0, p2_choice_o}, 8'h00);
    check("s4_acc_valid", {7'b0, round_valid_o}, 8'h00);
    cycles(3);
    check("s4_p2_still0", {6'b0, p2_choice_o}, 8'h00);
    btn_i = '0;
    cycles(40);

    // Reset mid-round (P1 paper locked) and mid-debounce (P1 rock ~2 ticks in)
    btn_i = 6'b000010;
    cycles(40);
    btn_i = '0;
    cycles(40);
    check("s5_locked", {6'b0, p1_choice_o}, 8'h02);
    btn_i = 6'b000001;
    cycles(18);
    reset_n = 1'b0;
    #1;
    check("s5_rst_p1", {6'b0, p1_choice_o}, 8'h00);
    check("s5_rst_level", {2'b0, btn_level_o}, 8'h00);
    cycles(3);
    reset_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_i);
      #2;
      if (btn_level_o[0]) begin
        lat = i;
        break;
      end
    end
    check("s5_redebounce", {7'b0, (lat >= 27 && lat <= 34)}, 8'h01);
    cycles(5);
    check("s5_relock", {6'b0, p1_choice_o}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
